pc_stack: RTL and testbench

// - Parametrised program counter for the simple processor: load, increment, call/return.
// - Adds a hardware return-address stack for subroutine support.
// - Sits between the control unit (control strobes) and the instruction-memory address bus (data_out).

---
 rtl/pc_stack.sv | 111 +++++++++++
 tb/tb_pc_stack.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Program counter with load/increment/call/return and a hardware return-address stack.
// Optional PC-relative branch input rel_en is built when PC_REL_BRANCH_EN is defined.
module pc_stack #(
  parameter int                 WIDTH       = 16,
  parameter int                 DEPTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = WIDTH'(1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_en,
  input  logic             write_en,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  input  logic             err_clr,
`ifdef PC_REL_BRANCH_EN
  input  logic             rel_en,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] pc_value,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus1;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             push;
  logic             err_set;
  logic [WIDTH-1:0] mem [DEPTH];

  assign pc_plus1 = pc + WIDTH'(1);
  assign wr_idx   = count[AW-1:0];
  assign top_idx  = count[AW-1:0] - AW'(1);
  assign pc_value = pc;

  // Exactly one PC action per cycle: ret > call > write_en > rel_en > inc.
  always_comb begin
    pc_next    = pc;
    count_next = count;
    push       = 1'b0;
    err_set    = 1'b0;
    if (ret) begin
      if (stack_empty) begin
        err_set = 1'b1;
      end else begin
        count_next = count - CW'(1);
        pc_next    = mem[top_idx];
      end
    end else if (call) begin
      if (stack_full) begin
        err_set = 1'b1;
      end else begin
        push       = 1'b1;
        count_next = count + CW'(1);
        pc_next    = data_in;
      end
    end else if (write_en) begin
      pc_next = data_in;
`ifdef PC_REL_BRANCH_EN
    end else if (rel_en) begin
      // Two's-complement add: unsigned wrap gives the signed offset result.
      pc_next = pc + data_in;
`endif
    end else if (inc) begin
      pc_next = pc_plus1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_VALUE;
      data_out    <= '0;
      count       <= '0;
      stack_full  <= 1'b0;
      stack_empty <= 1'b1;
      stack_err   <= 1'b0;
    end else begin
      pc          <= pc_next;
      count       <= count_next;
      stack_full  <= (count_next == CW'(DEPTH));
      stack_empty <= (count_next == '0);
      if (read_en) begin
        data_out <= pc;
      end
      // A new error in the same cycle as err_clr keeps the flag set.
      if (err_set) begin
        stack_err <= 1'b1;
      end else if (err_clr) begin
        stack_err <= 1'b0;
      end
    end
  end

  // Stack storage needs no reset; entries are only read below count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_idx] <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: directed vectors push expectations, a negedge monitor pops and checks.
module tb_pc_stack;

  logic        clock;
  logic        reset_n;
  logic [15:0] data_in;
  logic        read_en, write_en, inc, call, ret, err_clr;
`ifdef PC_REL_BRANCH_EN
  logic        rel_en;
`endif
  logic [15:0] data_out, pc_value;
  logic        stack_full, stack_empty, stack_err;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [15:0] dout;
    logic        full;
    logic        empty;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  localparam logic [5:0] RD  = 6'b100000;
  localparam logic [5:0] WR  = 6'b010000;
  localparam logic [5:0] INC = 6'b001000;
  localparam logic [5:0] CAL = 6'b000100;
  localparam logic [5:0] RET = 6'b000010;
  localparam logic [5:0] CLR = 6'b000001;
  localparam logic [5:0] NOP = 6'b000000;

  pc_stack #(.WIDTH(16), .DEPTH(8), .RESET_VALUE(16'd1)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .read_en     (read_en),
    .write_en    (write_en),
    .inc         (inc),
    .call        (call),
    .ret         (ret),
    .err_clr     (err_clr),
`ifdef PC_REL_BRANCH_EN
    .rel_en      (rel_en),
`endif
    .data_out    (data_out),
    .pc_value    (pc_value),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input string field,
                             input logic [15:0] actual, input logic [15:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, actual, required);
    end
  endtask

  task automatic pushExpect(input string name, input logic [15:0] e_pc, input logic [15:0] e_dout,
                            input logic e_full, input logic e_empty, input logic e_err);
    exp_t e;
    e.name = name; e.pc = e_pc; e.dout = e_dout;
    e.full = e_full; e.empty = e_empty; e.err = e_err;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of strobes at the negedge, then queue the state expected after the next posedge.
  task automatic applyStimulus(input string name, input logic [5:0] ctl, input logic [15:0] din,
                               input logic [15:0] e_pc, input logic [15:0] e_dout,
                               input logic e_full, input logic e_empty, input logic e_err);
    @(negedge clock);
    {read_en, write_en, inc, call, ret, err_clr} = ctl;
    data_in = din;
    @(posedge clock);
    pushExpect(name, e_pc, e_dout, e_full, e_empty, e_err);
  endtask

  // Monitor: every negedge with a pending expectation, compare all visible outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e.name, "pc_value", pc_value, e.pc);
        checkOutput(e.name, "data_out", data_out, e.dout);
        checkOutput(e.name, "stack_full", 16'(stack_full), 16'(e.full));
        checkOutput(e.name, "stack_empty", 16'(stack_empty), 16'(e.empty));
        checkOutput(e.name, "stack_err", 16'(stack_err), 16'(e.err));
      end
    end
  end

  initial begin
    logic [15:0] exp_pc;
    reset_n = 1'b0;
    {read_en, write_en, inc, call, ret, err_clr} = NOP;
    data_in = 16'h0;
`ifdef PC_REL_BRANCH_EN
    rel_en = 1'b0;
`endif
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    applyStimulus("reset_idle", NOP, 16'h0,    16'h0001, 16'h0000, 0, 1, 0);
    applyStimulus("reset_read", RD,  16'h0,    16'h0001, 16'h0001, 0, 1, 0);
    applyStimulus("inc1",       INC, 16'h0,    16'h0002, 16'h0001, 0, 1, 0);
    applyStimulus("inc2",       INC, 16'h0,    16'h0003, 16'h0001, 0, 1, 0);
    applyStimulus("inc3",       INC, 16'h0,    16'h0004, 16'h0001, 0, 1, 0);
    applyStimulus("read4",      RD,  16'h0,    16'h0004, 16'h0004, 0, 1, 0);
    applyStimulus("wr_rd_old",  WR|RD, 16'hFFFF, 16'hFFFF, 16'h0004, 0, 1, 0);
    applyStimulus("inc_wrap",   INC|RD, 16'h0, 16'h0000, 16'hFFFF, 0, 1, 0);
    applyStimulus("load5",      WR,  16'h0005, 16'h0005, 16'hFFFF, 0, 1, 0);
    applyStimulus("call100",    CAL, 16'h0100, 16'h0100, 16'hFFFF, 0, 0, 0);
    applyStimulus("ret6",       RET, 16'h0,    16'h0006, 16'hFFFF, 0, 1, 0);
    applyStimulus("loadmax",    WR,  16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1, 0);
    applyStimulus("call_atmax", CAL, 16'h0200, 16'h0200, 16'hFFFF, 0, 0, 0);
    applyStimulus("ret_wrap0",  RET, 16'h0,    16'h0000, 16'hFFFF, 0, 1, 0);

    // Fill the stack: first push is 0x11, then each call pushes its predecessor target + 1.
    applyStimulus("load10",     WR,  16'h0010, 16'h0010, 16'hFFFF, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      exp_pc = 16'h0020 + 16'(i);
      applyStimulus($sformatf("nest%0d", i), CAL, exp_pc, exp_pc, 16'hFFFF, (i == 7), 0, 0);
    end
    applyStimulus("overflow",   CAL, 16'h0300, 16'h0027, 16'hFFFF, 1, 0, 1);
    applyStimulus("clr",        CLR, 16'h0,    16'h0027, 16'hFFFF, 1, 0, 0);
    applyStimulus("clr_vs_err", CLR|CAL, 16'h0301, 16'h0027, 16'hFFFF, 1, 0, 1);
    applyStimulus("clr2",       CLR, 16'h0,    16'h0027, 16'hFFFF, 1, 0, 0);
    applyStimulus("ret_wins",   RET|CAL|WR|INC, 16'h0555, 16'h0027, 16'hFFFF, 0, 0, 0);
    for (int j = 1; j < 8; j++) begin
      exp_pc = (j == 7) ? 16'h0011 : (16'h0020 + 16'(7 - j));
      applyStimulus($sformatf("unwind%0d", j), RET, 16'h0, exp_pc, 16'hFFFF, 0, (j == 7), 0);
    end
    applyStimulus("underflow",  RET, 16'h0,    16'h0011, 16'hFFFF, 0, 1, 1);
    applyStimulus("clr3",       CLR, 16'h0,    16'h0011, 16'hFFFF, 0, 1, 0);
    applyStimulus("wr_over_inc", WR|INC, 16'h0020, 16'h0020, 16'hFFFF, 0, 1, 0);
    applyStimulus("call_over_wr", CAL|WR, 16'h0040, 16'h0040, 16'hFFFF, 0, 0, 0);
    applyStimulus("wr50",       WR|INC, 16'h0050, 16'h0050, 16'hFFFF, 0, 0, 0);
    applyStimulus("read50",     RD,  16'h0,    16'h0050, 16'h0050, 0, 0, 0);
`ifdef PC_REL_BRANCH_EN
    applyStimulus("load10b",    WR,  16'h0010, 16'h0010, 16'h0050, 0, 0, 0);
    @(negedge clock);
    {read_en, write_en, inc, call, ret, err_clr} = INC;
    rel_en = 1'b1;
    data_in = 16'hFFFC;
    @(posedge clock);
    pushExpect("rel_back4", 16'h000C, 16'h0050, 0, 0, 0);
    @(negedge clock);
    rel_en = 1'b0;
`endif
    applyStimulus("call80",     CAL, 16'h0080, 16'h0080, 16'h0050, 0, 0, 0);

    // Asynchronous reset between edges while the stack holds two entries.
    @(negedge clock);
    {read_en, write_en, inc, call, ret, err_clr} = NOP;
    @(posedge clock);
    #2 reset_n = 1'b0;
    pushExpect("async_reset", 16'h0001, 16'h0000, 0, 1, 0);
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus("post_reset", NOP, 16'h0,    16'h0001, 16'h0000, 0, 1, 0);
    applyStimulus("post_read",  RD,  16'h0,    16'h0001, 16'h0001, 0, 1, 0);
    applyStimulus("post_ret",   RET, 16'h0,    16'h0001, 16'h0001, 0, 1, 1);

    @(negedge clock);
    {read_en, write_en, inc, call, ret, err_clr} = NOP;
    repeat (2) @(negedge clock);
    checkOutput("scoreboard", "leftover", 16'(exp_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
